// File: rtl/alu_result_collector.sv
// Collects ALU result/flag samples into a first-word fall-through FIFO.
// Also keeps saturating per-flag event counters and a sticky flag for samples lost while full.
module alu_result_collector #(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_valid,
  input  logic [WIDTH-1:0]         i_result,
  input  logic [3:0]               i_flag,
  input  logic                     i_clr,
  input  logic                     i_ready,
  output logic                     o_valid,
  output logic [WIDTH-1:0]         o_result,
  output logic [3:0]               o_flag,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_drop,
  output logic [CNT_WIDTH-1:0]     o_err_cnt,
  output logic [CNT_WIDTH-1:0]     o_neg_cnt,
  output logic [CNT_WIDTH-1:0]     o_pos_cnt,
  output logic [CNT_WIDTH-1:0]     o_ovf_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = WIDTH + 4;
  localparam logic [AW:0]          FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  logic [DW-1:0]        mem [DEPTH];
  logic [AW:0]          wr_ptr;
  logic [AW:0]          rd_ptr;
  logic [CNT_WIDTH-1:0] cnt [4];
  logic                 drop;
  logic                 empty;
  logic                 pop;
  logic                 push;
  logic [DW-1:0]        head;

  // Pointers carry an extra MSB so the difference distinguishes full from empty.
  assign o_level  = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign o_valid  = ~empty;
  assign o_full   = (o_level == FULL_LVL);
  assign pop      = o_valid & i_ready;
  assign push     = i_valid & (~o_full | pop);

  // Stale storage is masked so the data outputs read zero while empty.
  assign head     = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign o_result = head[DW-1:4];
  assign o_flag   = head[3:0];
  assign o_drop   = drop;

  assign o_err_cnt = cnt[0];
  assign o_neg_cnt = cnt[1];
  assign o_pos_cnt = cnt[2];
  assign o_ovf_cnt = cnt[3];

  always_ff @(posedge i_clk) begin
    if (push && !i_clr) begin
      mem[wr_ptr[AW-1:0]] <= {i_result, i_flag};
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      drop   <= 1'b0;
    end else if (i_clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      drop   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (i_valid && o_full && !pop) drop <= 1'b1;
    end
  end

  // Dropped samples still count: the statistics describe the ALU stream, not the FIFO.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int k = 0; k < 4; k++) cnt[k] <= '0;
    end else if (i_clr) begin
      for (int k = 0; k < 4; k++) cnt[k] <= '0;
    end else if (i_valid) begin
      for (int k = 0; k < 4; k++) begin
        if (i_flag[k] && (cnt[k] != CNT_MAX)) cnt[k] <= cnt[k] + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_collector.sv
// Bench for alu_result_collector: a scoreboard queue receives each expected FIFO entry as the
// sample is driven, a monitor pops it on every handshake, and directed checks cover levels and counters.
module tb_alu_result_collector;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int CNT_WIDTH = 8;

  logic                 i_clk = 1'b0;
  logic                 i_rstn;
  logic                 i_valid;
  logic [WIDTH-1:0]     i_result;
  logic [3:0]           i_flag;
  logic                 i_clr;
  logic                 i_ready;
  logic                 o_valid;
  logic [WIDTH-1:0]     o_result;
  logic [3:0]           o_flag;
  logic [2:0]           o_level;
  logic                 o_full;
  logic                 o_drop;
  logic [CNT_WIDTH-1:0] o_err_cnt;
  logic [CNT_WIDTH-1:0] o_neg_cnt;
  logic [CNT_WIDTH-1:0] o_pos_cnt;
  logic [CNT_WIDTH-1:0] o_ovf_cnt;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  alu_result_collector #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_valid(i_valid), .i_result(i_result),
    .i_flag(i_flag), .i_clr(i_clr), .i_ready(i_ready), .o_valid(o_valid),
    .o_result(o_result), .o_flag(o_flag), .o_level(o_level), .o_full(o_full),
    .o_drop(o_drop), .o_err_cnt(o_err_cnt), .o_neg_cnt(o_neg_cnt),
    .o_pos_cnt(o_pos_cnt), .o_ovf_cnt(o_ovf_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_cnt(input string tag, input int e, input int n, input int p, input int v);
    check({tag, "_err_cnt"}, o_err_cnt, e);
    check({tag, "_neg_cnt"}, o_neg_cnt, n);
    check({tag, "_pos_cnt"}, o_pos_cnt, p);
    check({tag, "_ovf_cnt"}, o_ovf_cnt, v);
  endtask

  // One clock cycle of stimulus; the expected entry is queued when the sample will be accepted.
  task automatic cyc(input logic v, input logic [3:0] r, input logic [3:0] f,
                     input logic rdy, input logic clr);
    logic will_pop;
    i_valid  = v;
    i_result = r;
    i_flag   = f;
    i_ready  = rdy;
    i_clr    = clr;
    will_pop = rdy && (exp_q.size() > 0);
    if (!clr && v && ((exp_q.size() < DEPTH) || will_pop)) exp_q.push_back({r, f});
    @(posedge i_clk);
    #1;
    if (clr) exp_q.delete();
  endtask

  always @(negedge i_clk) begin
    if (i_rstn && o_valid && i_ready && !i_clr) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got %0d/%b expected no entry at %0t", o_result, o_flag, $time);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("pop_data", {o_result, o_flag}, e);
      end
    end
  end

  initial begin
    i_rstn = 1'b0; i_valid = 1'b1; i_result = 4'd5; i_flag = 4'b1111;
    i_clr = 1'b0; i_ready = 1'b0;
    repeat (2) begin
      @(negedge i_clk);
      check("rst_valid", o_valid, 0);
      check("rst_level", o_level, 0);
      check("rst_data", {o_result, o_flag}, 0);
      check_cnt("rst", 0, 0, 0, 0);
    end
    i_rstn = 1'b1;
    i_valid = 1'b0;
    @(posedge i_clk); #1;
    cyc(0, 0, 0, 0, 0);
    check("post_rst_level", o_level, 0);

    // single capture
    cyc(1, 4'd4, 4'b0100, 0, 0);
    check("single_valid", o_valid, 1);
    check("single_result", o_result, 4);
    check("single_flag", o_flag, 4'b0100);
    check("single_level", o_level, 1);
    check_cnt("single", 0, 0, 1, 0);

    // fill and drop
    cyc(0, 0, 0, 0, 1);
    check("clr_level", o_level, 0);
    check_cnt("clr", 0, 0, 0, 0);
    cyc(1, 4'd4,  4'b0100, 0, 0);
    cyc(1, 4'd14, 4'b0010, 0, 0);
    cyc(1, 4'd2,  4'b0100, 0, 0);
    cyc(1, 4'd6,  4'b0100, 0, 0);
    check("fill_full", o_full, 1);
    check("fill_drop_before", o_drop, 0);
    cyc(1, 4'd1,  4'b0100, 0, 0);
    check("fill_level", o_level, 4);
    check("fill_drop", o_drop, 1);
    check("fill_head_held", o_result, 4);
    check_cnt("fill", 0, 1, 4, 0);
    repeat (4) cyc(0, 0, 0, 1, 0);
    check("drain_valid", o_valid, 0);
    check("drain_data_zero", {o_result, o_flag}, 0);
    check("drain_drop_sticky", o_drop, 1);

    // full with simultaneous push/pop
    cyc(0, 0, 0, 0, 1);
    check("clr2_drop", o_drop, 0);
    cyc(1, 4'd3, 4'b0100, 0, 0);
    cyc(1, 4'd5, 4'b0100, 0, 0);
    cyc(1, 4'd7, 4'b0100, 0, 0);
    cyc(1, 4'd9, 4'b0010, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 4'(10 + i), 4'b0010, 1, 0);
      check("pp_level", o_level, 4);
      check("pp_drop", o_drop, 0);
    end
    check("pp_head", o_result, 9);
    repeat (4) cyc(0, 0, 0, 1, 0);
    check("pp_empty", o_level, 0);

    // counter saturation
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 254; i++) cyc(1, 4'(i), 4'b1010, 1, 0);
    check("sat_neg_254", o_neg_cnt, 254);
    for (int i = 254; i < 300; i++) cyc(1, 4'(i), 4'b1010, 1, 0);
    check_cnt("sat", 0, 255, 0, 255);
    cyc(0, 0, 0, 1, 0);
    check("sat_drained", o_level, 0);

    // clear vs reset
    cyc(0, 0, 0, 0, 1);
    for (int i = 1; i <= 5; i++) cyc(1, 4'(i), 4'b0100, 0, 0);
    cyc(0, 0, 0, 1, 0);
    check("cv_level", o_level, 3);
    check("cv_drop", o_drop, 1);
    cyc(1, 4'd7, 4'b1111, 0, 1);
    check("cv_clr_level", o_level, 0);
    check("cv_clr_drop", o_drop, 0);
    check("cv_clr_valid", o_valid, 0);
    check_cnt("cv_clr", 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) cyc(1, 4'(i), 4'b0100, 0, 0);
    check("rm_level", o_level, 3);
    i_valid = 1'b0;
    @(negedge i_clk);
    i_rstn = 1'b0;
    #1;
    check("rm_valid", o_valid, 0);
    check("rm_level0", o_level, 0);
    check_cnt("rm", 0, 0, 0, 0);
    exp_q.delete();
    @(negedge i_clk);
    i_rstn = 1'b1;
    @(posedge i_clk); #1;
    cyc(1, 4'd8, 4'b0100, 0, 0);
    check("rm_first_result", o_result, 8);
    check("rm_first_level", o_level, 1);
    cyc(0, 0, 0, 1, 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
